fetch_prefetch_unit: RTL and testbench

- Parametrised instruction-fetch stage that replaces the single-register PC, PC+increment and mux arrangement.
- Owns the fetch PC and issues reads to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned instructions in a DEPTH-entry prefetch FIFO and presents them to decode over a valid/ready handshake.
- Supports branch redirect: PC load, FIFO flush and kill of the in-flight read.

---
 rtl/fetch_prefetch_unit.sv | 97 +++++++++
 tb/tb_fetch_prefetch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues 1-cycle-latency memory reads and
// buffers returned instructions in a prefetch FIFO presented to decode via valid/ready.
module fetch_prefetch_unit #(
    parameter int                 ADDR_W   = 16,
    parameter int                 INSTR_W  = 16,
    parameter int                 PC_INCR  = 4,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                         clock,
    input  logic                         resetN,
    input  logic                         redirectValid,
    input  logic [ADDR_W-1:0]            redirectAddr,
    output logic                         memReq,
    output logic [ADDR_W-1:0]            memAddr,
    input  logic [INSTR_W-1:0]           memRdata,
    output logic                         instrValid,
    output logic [INSTR_W-1:0]           instrData,
    output logic [ADDR_W-1:0]            instrPC,
    output logic [ADDR_W-1:0]            instrPCNext,
    input  logic                         instrReady,
    output logic [$clog2(DEPTH+1)-1:0]   fifoCount
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  tag_pc;
    logic               inflight;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [INSTR_W-1:0] data_q [DEPTH];
    logic [ADDR_W-1:0]  pc_q   [DEPTH];

    logic [CNT_W:0]     occ;
    logic               issue;
    logic               push;
    logic               pop;

    // Occupancy includes the read in flight so a response always has a free slot;
    // a same-cycle pop is intentionally not credited.
    assign occ   = {1'b0, count} + (CNT_W+1)'(inflight);
    assign issue = resetN & ~redirectValid & (occ < (CNT_W+1)'(DEPTH));
    assign push  = inflight & ~redirectValid;
    assign pop   = (count != '0) & instrReady;

    assign memReq      = issue;
    assign memAddr     = fetch_pc;
    assign instrValid  = (count != '0);
    assign instrData   = data_q[head];
    assign instrPC     = pc_q[head];
    assign instrPCNext = pc_q[head] + ADDR_W'(PC_INCR);
    assign fifoCount   = count;

    always_ff @(posedge clock) begin
        if (!resetN) begin
            fetch_pc <= RESET_PC;
            tag_pc   <= '0;
            inflight <= 1'b0;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else if (redirectValid) begin
            fetch_pc <= redirectAddr;
            inflight <= 1'b0;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + ADDR_W'(PC_INCR);
                tag_pc   <= fetch_pc;
            end
            if (push)
                tail <= tail + PTR_W'(1);
            if (pop)
                head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once count covers them.
    always_ff @(posedge clock) begin
        if (resetN && push) begin
            data_q[tail] <= memRdata;
            pc_q[tail]   <= tag_pc;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with hand-computed expectations; a second
// instance with RESET_PC=FFF8 exercises PC wrap-around.
module tb_fetch_prefetch_unit;

    logic        clock;
    logic        resetN;
    logic        redirectValid;
    logic [15:0] redirectAddr;
    logic        memReq;
    logic [15:0] memAddr;
    logic [15:0] memRdata;
    logic        instrValid;
    logic [15:0] instrData;
    logic [15:0] instrPC;
    logic [15:0] instrPCNext;
    logic        instrReady;
    logic [2:0]  fifoCount;

    logic        w_memReq;
    logic [15:0] w_memAddr;
    logic [15:0] w_memRdata;
    logic        w_instrValid;
    logic [15:0] w_instrData;
    logic [15:0] w_instrPC;
    logic [15:0] w_instrPCNext;
    logic [2:0]  w_fifoCount;

    int n_chk  = 0;
    int n_pass = 0;

    fetch_prefetch_unit #(.ADDR_W(16), .INSTR_W(16), .PC_INCR(4), .DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clock(clock), .resetN(resetN), .redirectValid(redirectValid), .redirectAddr(redirectAddr),
        .memReq(memReq), .memAddr(memAddr), .memRdata(memRdata),
        .instrValid(instrValid), .instrData(instrData), .instrPC(instrPC),
        .instrPCNext(instrPCNext), .instrReady(instrReady), .fifoCount(fifoCount)
    );

    fetch_prefetch_unit #(.ADDR_W(16), .INSTR_W(16), .PC_INCR(4), .DEPTH(4), .RESET_PC(16'hFFF8)) dut_w (
        .clock(clock), .resetN(resetN), .redirectValid(1'b0), .redirectAddr(16'h0000),
        .memReq(w_memReq), .memAddr(w_memAddr), .memRdata(w_memRdata),
        .instrValid(w_instrValid), .instrData(w_instrData), .instrPC(w_instrPC),
        .instrPCNext(w_instrPCNext), .instrReady(1'b1), .fifoCount(w_fifoCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous instruction memory: data = addr ^ A5A5, one cycle after request.
    always @(posedge clock) begin
        if (memReq)   memRdata   <= memAddr ^ 16'hA5A5;
        if (w_memReq) w_memRdata <= w_memAddr ^ 16'hA5A5;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, expv);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    logic [15:0] e;
    logic [2:0]  cnt_tbl [7] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};

    initial begin
        resetN        = 1'b0;
        redirectValid = 1'b0;
        redirectAddr  = 16'h0000;
        instrReady    = 1'b1;

        // Reset then stream
        step();
        step();
        chk("rst_memReq",    32'(memReq),     32'd0);
        chk("rst_valid",     32'(instrValid), 32'd0);
        chk("rst_count",     32'(fifoCount),  32'd0);
        chk("rst_w_memReq",  32'(w_memReq),   32'd0);
        resetN = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("stream_memReq",  32'(memReq),  32'd1);
            chk("stream_memAddr", 32'(memAddr), 32'(16'(4 * k)));
            e = 16'hFFF8 + 16'(4 * k);
            chk("wrap_memAddr", 32'(w_memAddr), 32'(e));
            if (k < 2) begin
                chk("stream_valid_lo", 32'(instrValid), 32'd0);
            end else begin
                e = 16'(4 * (k - 2));
                chk("stream_valid",  32'(instrValid),  32'd1);
                chk("stream_pc",     32'(instrPC),     32'(e));
                chk("stream_pcnext", 32'(instrPCNext), 32'(16'(e + 16'd4)));
                chk("stream_data",   32'(instrData),   32'(e ^ 16'hA5A5));
                e = 16'hFFF8 + 16'(4 * (k - 2));
                chk("wrap_pc",     32'(w_instrPC),     32'(e));
                chk("wrap_pcnext", 32'(w_instrPCNext), 32'(16'(e + 16'd4)));
            end
            step();
        end

        // Backpressure
        resetN = 1'b0; instrReady = 1'b0;
        step();
        resetN = 1'b1;
        for (int k = 0; k < 7; k++) begin
            #1;
            chk("bp_memReq",  32'(memReq),    (k < 4) ? 32'd1 : 32'd0);
            chk("bp_memAddr", 32'(memAddr),   32'(16'(4 * ((k < 4) ? k : 4))));
            chk("bp_count",   32'(fifoCount), 32'(cnt_tbl[k]));
            if (k >= 2) begin
                chk("bp_head_pc",   32'(instrPC),   32'h0000);
                chk("bp_head_data", 32'(instrData), 32'hA5A5);
            end
            step();
        end
        instrReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (i == 0) chk("bp_full_pop_noissue", 32'(memReq), 32'd0);
            if (i == 1) begin
                chk("bp_resume_req",  32'(memReq),  32'd1);
                chk("bp_resume_addr", 32'(memAddr), 32'h0010);
            end
            chk("drain_valid", 32'(instrValid), 32'd1);
            chk("drain_pc",    32'(instrPC),    32'(16'(4 * i)));
            chk("drain_data",  32'(instrData),  32'(16'(4 * i) ^ 16'hA5A5));
            step();
        end

        // Redirect with read in flight
        resetN = 1'b0;
        step();
        resetN = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                #1;
                chk("rd_issue_0010", 32'(memAddr), 32'h0010);
            end
            step();
        end
        redirectValid = 1'b1; redirectAddr = 16'h0100;
        #1;
        chk("rd_memReq_blocked", 32'(memReq), 32'd0);
        step();
        redirectValid = 1'b0;
        #1;
        chk("rd_count0",  32'(fifoCount),  32'd0);
        chk("rd_valid0",  32'(instrValid), 32'd0);
        chk("rd_memAddr", 32'(memAddr),    32'h0100);
        chk("rd_memReq",  32'(memReq),     32'd1);
        step();
        chk("rd_killed", 32'(instrValid), 32'd0);
        step();
        chk("rd_first_valid", 32'(instrValid), 32'd1);
        chk("rd_first_pc",    32'(instrPC),    32'h0100);
        chk("rd_first_data",  32'(instrData),  32'hA4A5);
        step();
        chk("rd_second_pc", 32'(instrPC), 32'h0104);

        // Simultaneous redirect and pop with 3 entries buffered
        resetN = 1'b0; instrReady = 1'b0;
        step();
        resetN = 1'b1;
        repeat (4) step();
        chk("rp_count3", 32'(fifoCount), 32'd3);
        instrReady = 1'b1; redirectValid = 1'b1; redirectAddr = 16'h0200;
        #1;
        chk("rp_valid",  32'(instrValid), 32'd1);
        chk("rp_memReq", 32'(memReq),     32'd0);
        step();
        redirectValid = 1'b0;
        #1;
        chk("rp_count0",  32'(fifoCount),  32'd0);
        chk("rp_valid0",  32'(instrValid), 32'd0);
        chk("rp_memAddr", 32'(memAddr),    32'h0200);
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            chk("rp_valid_after", 32'(instrValid), 32'd1);
            chk("rp_pc_after",    32'(instrPC),    32'(16'h0200 + 16'(4 * i)));
            step();
        end

        // Reset mid-stream with count=3 and a read in flight
        resetN = 1'b0;
        step();
        resetN = 1'b1; instrReady = 1'b0;
        repeat (4) step();
        chk("mr_count3", 32'(fifoCount), 32'd3);
        resetN = 1'b0;
        #1;
        chk("mr_memReq_gated", 32'(memReq), 32'd0);
        step();
        chk("mr_count0", 32'(fifoCount),  32'd0);
        chk("mr_valid0", 32'(instrValid), 32'd0);
        chk("mr_memReq", 32'(memReq),     32'd0);
        resetN = 1'b1; instrReady = 1'b1;
        #1;
        chk("mr_restart_req",  32'(memReq),  32'd1);
        chk("mr_restart_addr", 32'(memAddr), 32'h0000);
        step();
        chk("mr_stale_dropped", 32'(instrValid), 32'd0);
        step();
        chk("mr_first_valid", 32'(instrValid), 32'd1);
        chk("mr_first_pc",    32'(instrPC),    32'h0000);
        chk("mr_first_data",  32'(instrData),  32'hA5A5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
